hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Next-generation hazard unit for the 5-stage pipelined RISC-V core.
- Generalises the forward-only unit in three ways:
  - parametrised register-address width;
  - load-use stall and branch/jump flush generation;
  - a wait-state FSM that freezes the pipeline while a multi-cycle data-memory access sits in Memory.
- Drives the enable/clear pins of the F/D, D/E, E/M and M/W pipeline registers and the two forwarding muxes ahead of the ALU.

Parameters:
- REG_ADDR_W, 5: register index width; index 0 is hard-wired zero.
- WAIT_STATES, 0: extra cycles per data-memory access; legal 0..15; 0 means single-cycle memory.
- PERF_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Rs1D  in  REG_ADDR_W  rs1 of instruction in Decode
- Rs2D  in  REG_ADDR_W  rs2 of instruction in Decode
- Rs1E  in  REG_ADDR_W  rs1 of instruction in Execute
- Rs2E  in  REG_ADDR_W  rs2 of instruction in Execute
- RdE  in  REG_ADDR_W  rd in Execute
- RdM  in  REG_ADDR_W  rd in Memory
- RdW  in  REG_ADDR_W  rd in Writeback
- ResultSrcE  in  2  result select in Execute; 2'b01 = load
- RegWriteM  in  1  register write in Memory
- RegWriteW  in  1  register write in Writeback
- MemAccessM  in  1  load or store occupying Memory
- PCSrcE  in  1  taken branch/jump resolved in Execute
- StallF  out  1  hold PC
- StallD  out  1  hold F/D register
- StallE  out  1  hold D/E register
- StallM  out  1  hold E/M register
- FlushD  out  1  clear F/D register
- FlushE  out  1  clear D/E register
- FlushW  out  1  clear M/W register (bubble)
- ForwardAE  out  2  SrcA select: 00 = RD1E, 01 = ResultW, 10 = ALUResultM
- ForwardBE  out  2  SrcB select, same encoding

Behaviour:
- Reset: reset low forces FSM to IDLE and counter to 0, asynchronously. While reset is low, all outputs are 0. Reset mid-WAIT aborts the access; no stall on release.

Forwarding (combinational):
- ForwardAE = 10 if RegWriteM && RdM==Rs1E && Rs1E!=0.
- Else ForwardAE = 01 if RegWriteW && RdW==Rs1E && Rs1E!=0.
- Else ForwardAE = 00.
- ForwardBE uses Rs2E with the same rules.
- Memory takes priority over Writeback.

Load-use:
- lwStall = (ResultSrcE==01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- lwEff = lwStall && !PCSrcE (a redirect kills the dependent instruction).

Memory wait FSM (IDLE, WAIT; 4-bit down-counter cnt):
- memStall = (IDLE && MemAccessM && WAIT_STATES!=0) || (WAIT && MemAccessM && cnt!=0).
- IDLE with memStall: cnt <= WAIT_STATES-1, go to WAIT.
- WAIT with cnt!=0 and MemAccessM: cnt <= cnt-1.
- WAIT with cnt==0: no stall; go to IDLE (access completes this cycle).
- WAIT with MemAccessM low (protocol violation): no stall; go to IDLE next edge.
- Each access incurs exactly WAIT_STATES stall cycles. Back-to-back accesses each pay the full penalty.
- WAIT_STATES=0: FSM stays in IDLE permanently.

Output priority:
1. memStall: StallF=StallD=StallE=StallM=1, FlushW=1. FlushD=FlushE=0, lwEff is ignored, and Execute is re-evaluated after release.
2. Otherwise: StallF=StallD=lwEff; FlushE=lwEff|PCSrcE; FlushD=PCSrcE. StallE, StallM and FlushW are 0.

- Forwarding outputs stay valid during memStall.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds input perf_clear (1, synchronous, active-high) and outputs perf_lw_stalls, perf_mem_stalls and perf_flushes (each PERF_W).
  - Counters increment once per cycle with lwEff, memStall and PCSrcE&&!memStall respectively.
  - Counters saturate at all-ones, reset to 0 on reset, and clear on perf_clear. perf_clear wins over increment.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Same with Rs1E=0 -> ForwardAE=00. RdM=6, Rs2E=5 -> ForwardBE=01.
- ResultSrcE=01, RdE=7, Rs2D=7, PCSrcE=0 -> StallF=StallD=FlushE=1 for exactly 1 cycle. Same with PCSrcE=1 -> StallF=0, FlushD=FlushE=1.
- WAIT_STATES=2, MemAccessM=1 held 3 cycles -> StallF..StallM=1 and FlushW=1 on cycles 0 and 1, all 0 on cycle 2; FSM back in IDLE on cycle 3.
- WAIT_STATES=2, PCSrcE=1 and lwStall during memStall -> FlushD=FlushE=StallF-from-lw=0 until memStall drops, then FlushD=FlushE=1.
- reset low during WAIT (cnt=1) -> all outputs 0 immediately. After release with MemAccessM=0 -> no stall.
- HAZARD_PERF_EN, PERF_W=4: 20 load-use cycles -> perf_lw_stalls=15 (saturated); perf_clear=1 for one edge -> 0.

Source files
------------

// File: rtl/hazard_ctrl_unit_if.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_unit_if : pipeline <-> hazard unit signal bundle
// Rev 1.0 : initial release
// ============================================================================
interface hazard_ctrl_unit_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]            ResultSrcE;
  logic                  RegWriteM, RegWriteW, MemAccessM, PCSrcE;
  logic                  StallF, StallD, StallE, StallM;
  logic                  FlushD, FlushE, FlushW;
  logic [1:0]            ForwardAE, ForwardBE;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
    output RegWriteM, RegWriteW, MemAccessM, PCSrcE,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
    input  RegWriteM, RegWriteW, MemAccessM, PCSrcE,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_unit : forwarding, load-use stall, redirect flush and
//                    data-memory wait-state freeze for the 5-stage core.
// Optional macro HAZARD_PERF_EN : saturating lw/mem-stall/flush counters.
// Rev 1.0 : initial release
// ============================================================================
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int WAIT_STATES = 0,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  hazard_ctrl_unit_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  input  logic              perf_clear,
  output logic [PERF_W-1:0] perf_lw_stalls,
  output logic [PERF_W-1:0] perf_mem_stalls,
  output logic [PERF_W-1:0] perf_flushes
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [REG_ADDR_W-1:0] c_X0      = '0;
  localparam logic [3:0]            c_WS_M1   = 4'(WAIT_STATES - 1);
  localparam bit                    c_HAS_WS  = (WAIT_STATES != 0);

  if (WAIT_STATES < 0 || WAIT_STATES > 15 || PERF_W < 1) begin : g_param_chk
    $error("hazard_ctrl_unit: WAIT_STATES must be 0..15 and PERF_W >= 1");
  end

  logic [0:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mem_stall, lw_stall, lw_eff;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs, rdm, rdw,
    input logic                  wm, ww
  );
    if (wm && rdm == rs && rs != c_X0)      return 2'b10;
    else if (ww && rdw == rs && rs != c_X0) return 2'b01;
    else                                    return 2'b00;
  endfunction

  assign lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != c_X0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign lw_eff   = lw_stall && !hz.PCSrcE;

  // The counter is loaded with WAIT_STATES-1 on entry, so the entry cycle
  // plus cnt down to 1 gives exactly WAIT_STATES stall cycles per access.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hz.MemAccessM && c_HAS_WS) begin
          mem_stall = 1'b1;
          cnt_d     = c_WS_M1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (hz.MemAccessM && cnt_q != 4'd0) begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q - 4'd1;
        end else begin
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.StallM    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushW    = 1'b0;
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (reset) begin
      hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
      hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
      // A memory freeze holds Execute intact, so redirects and load-use are
      // simply re-evaluated once the access releases.
      if (mem_stall) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.StallM = 1'b1;
        hz.FlushW = 1'b1;
      end else begin
        hz.StallF = lw_eff;
        hz.StallD = lw_eff;
        hz.FlushE = lw_eff | hz.PCSrcE;
        hz.FlushD = hz.PCSrcE;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] lw_cnt_q, mem_cnt_q, fl_cnt_q;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    return (en && v != '1) ? v + {{(PERF_W-1){1'b0}}, 1'b1} : v;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lw_cnt_q  <= '0;
      mem_cnt_q <= '0;
      fl_cnt_q  <= '0;
    end else if (perf_clear) begin
      lw_cnt_q  <= '0;
      mem_cnt_q <= '0;
      fl_cnt_q  <= '0;
    end else begin
      lw_cnt_q  <= sat_inc(lw_cnt_q, lw_eff);
      mem_cnt_q <= sat_inc(mem_cnt_q, mem_stall);
      fl_cnt_q  <= sat_inc(fl_cnt_q, hz.PCSrcE && !mem_stall);
    end
  end

  assign perf_lw_stalls  = lw_cnt_q;
  assign perf_mem_stalls = mem_cnt_q;
  assign perf_flushes    = fl_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl_unit : directed vectors with a scoreboard queue, WAIT_STATES=2
// Rev 1.0 : initial release
// ============================================================================
module tb_hazard_ctrl_unit;

`ifdef HAZARD_PERF_EN
  localparam int PERF_W = 4;
`else
  localparam int PERF_W = 32;
`endif

  // expected word: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,FwdA,FwdB}
  localparam logic [10:0] E_0   = 11'b0000_000_00_00;
  localparam logic [10:0] E_MEM = 11'b1111_001_00_00;
  localparam logic [10:0] E_LW  = 11'b1100_010_00_00;
  localparam logic [10:0] E_BR  = 11'b0000_110_00_00;
  localparam logic [10:0] FA_M  = 11'b0000_000_10_00;
  localparam logic [10:0] FA_W  = 11'b0000_000_01_00;
  localparam logic [10:0] FB_W  = 11'b0000_000_00_01;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  hazard_ctrl_unit_if #(.REG_ADDR_W(5)) ifc ();

`ifdef HAZARD_PERF_EN
  logic              perf_clear;
  logic [PERF_W-1:0] perf_lw_stalls, perf_mem_stalls, perf_flushes;
`endif

  hazard_ctrl_unit #(.REG_ADDR_W(5), .WAIT_STATES(2), .PERF_W(PERF_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .hz              (ifc.slave)
`ifdef HAZARD_PERF_EN
    ,
    .perf_clear      (perf_clear),
    .perf_lw_stalls  (perf_lw_stalls),
    .perf_mem_stalls (perf_mem_stalls),
    .perf_flushes    (perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [10:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [10:0] act;

  assign act = {ifc.StallF, ifc.StallD, ifc.StallE, ifc.StallM,
                ifc.FlushD, ifc.FlushE, ifc.FlushW, ifc.ForwardAE, ifc.ForwardBE};

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (act !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
      end
    end
  end

  task automatic vec(input string nm, input logic rst,
                     input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                     input logic [1:0] rsrc, input logic rwm, rww, mem, pc,
                     input logic [10:0] exp);
    @(posedge clk);
    #1;
    reset          = rst;
    ifc.Rs1D       = rs1d;
    ifc.Rs2D       = rs2d;
    ifc.Rs1E       = rs1e;
    ifc.Rs2E       = rs2e;
    ifc.RdE        = rde;
    ifc.RdM        = rdm;
    ifc.RdW        = rdw;
    ifc.ResultSrcE = rsrc;
    ifc.RegWriteM  = rwm;
    ifc.RegWriteW  = rww;
    ifc.MemAccessM = mem;
    ifc.PCSrcE     = pc;
    sb_q.push_back('{nm, exp});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    {ifc.Rs1D, ifc.Rs2D, ifc.Rs1E, ifc.Rs2E, ifc.RdE, ifc.RdM, ifc.RdW} = '0;
    ifc.ResultSrcE = 2'b00;
    {ifc.RegWriteM, ifc.RegWriteW, ifc.MemAccessM, ifc.PCSrcE} = '0;
`ifdef HAZARD_PERF_EN
    perf_clear = 1'b0;
`endif
    //   name            rst rs1d rs2d rs1e rs2e rde rdm rdw rsrc  rwm rww mem pc exp
    vec("reset_hold",     0, 0, 0, 5, 5, 0, 5, 5, 2'b00, 1, 1, 1, 1, E_0);
    vec("idle",           1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, E_0);
    vec("fwdA_mem_prio",  1, 0, 0, 5, 0, 0, 5, 5, 2'b00, 1, 1, 0, 0, FA_M);
    vec("fwd_x0",         1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, E_0);
    vec("fwdB_wb",        1, 0, 0, 6, 5, 0, 6, 5, 2'b00, 1, 1, 0, 0, FA_M | FB_W);
    vec("fwd_nowriteM",   1, 0, 0, 5, 6, 0, 6, 5, 2'b00, 0, 1, 0, 0, FA_W);
    vec("fwd_nowrite",    1, 0, 0, 5, 5, 0, 5, 5, 2'b00, 0, 0, 0, 0, E_0);
    vec("lw_use_rs2",     1, 0, 7, 0, 0, 7, 0, 0, 2'b01, 0, 0, 0, 0, E_LW);
    vec("lw_released",    1, 0, 7, 0, 0, 7, 0, 0, 2'b00, 0, 0, 0, 0, E_0);
    vec("lw_use_rs1",     1, 7, 0, 0, 0, 7, 0, 0, 2'b01, 0, 0, 0, 0, E_LW);
    vec("lw_redirect",    1, 0, 7, 0, 0, 7, 0, 0, 2'b01, 0, 0, 0, 1, E_BR);
    vec("lw_rd0",         1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, E_0);
    vec("not_load",       1, 7, 0, 0, 0, 7, 0, 0, 2'b10, 0, 0, 0, 0, E_0);
    vec("branch",         1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, E_BR);
    // single access, forwarding still live during the freeze
    vec("mem_c0_fwd",     1, 0, 0, 5, 0, 0, 5, 0, 2'b00, 1, 0, 1, 0, E_MEM | FA_M);
    vec("mem_c1",         1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, E_MEM);
    vec("mem_c2_done",    1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, E_0);
    vec("mem_c3_idle",    1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, E_0);
    // back-to-back accesses each pay the full penalty
    vec("b2b_a0",         1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, E_MEM);
    vec("b2b_a1",         1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, E_MEM);
    vec("b2b_a2",         1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, E_0);
    vec("b2b_b0",         1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, E_MEM);
    vec("b2b_b1",         1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, E_MEM);
    vec("b2b_b2",         1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, E_0);
    vec("b2b_idle",       1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, E_0);
    // redirect and load-use masked by the freeze, then applied
    vec("memhz_c0",       1, 7, 0, 0, 0, 7, 0, 0, 2'b01, 0, 0, 1, 1, E_MEM);
    vec("memhz_c1",       1, 7, 0, 0, 0, 7, 0, 0, 2'b01, 0, 0, 1, 1, E_MEM);
    vec("memhz_c2",       1, 7, 0, 0, 0, 7, 0, 0, 2'b01, 0, 0, 1, 1, E_BR);
    vec("memhz_idle",     1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, E_0);
    // MemAccessM dropped mid-wait returns to IDLE
    vec("abort_c0",       1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, E_MEM);
    vec("abort_drop",     1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, E_0);
    vec("abort_new0",     1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, E_MEM);
    vec("abort_new1",     1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, E_MEM);
    vec("abort_new2",     1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, E_0);
    vec("abort_idle",     1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, E_0);
    // reset during WAIT with cnt=1
    vec("rstw_c0",        1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, E_MEM);
    vec("rstw_assert",    0, 0, 0, 5, 0, 0, 5, 0, 2'b00, 1, 0, 1, 1, E_0);
    vec("rstw_release",   1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, E_0);
    vec("rstw_new0",      1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, E_MEM);
    vec("rstw_new1",      1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, E_MEM);
    vec("rstw_new2",      1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, E_0);
    vec("rstw_idle",      1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, E_0);
`ifdef HAZARD_PERF_EN
    for (int i = 0; i < 20; i++)
      vec("perf_lw",      1, 0, 7, 0, 0, 7, 0, 0, 2'b01, 0, 0, 0, 0, E_LW);
    vec("perf_idle",      1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, E_0);
    @(negedge clk);
    n_checks++;
    if (perf_lw_stalls !== 4'hF) begin
      n_errors++;
      $display("FAIL perf_lw_sat: got %0d expected 15", perf_lw_stalls);
    end
    @(posedge clk);
    #1 perf_clear = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (perf_lw_stalls !== 4'h0) begin
      n_errors++;
      $display("FAIL perf_clear: got %0d expected 0", perf_lw_stalls);
    end
    perf_clear = 1'b0;
`endif
    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
